// File: rtl/gate_sweep_pkg.sv
// ============================================================================
//  Module      : gate_sweep_pkg
//  Description : Shared constants and state type for the gate sweep controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_sweep_pkg;

    localparam int NUM_VEC       = 4;
    localparam int DEFAULT_OUT_W = 10;
    localparam int CNT_W         = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } sweep_state_e;

endpackage

`default_nettype wire

// File: rtl/gate_sweep_ctrl.sv
// ============================================================================
//  Module      : gate_sweep_ctrl
//  Description : Walks an external 2-input gate unit through all four input
//                vectors, captures its truth table and checks it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int OUT_W  = DEFAULT_OUT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [OUT_W-1:0]           gate_out,
    input  logic [NUM_VEC*OUT_W-1:0]   exp_table,
    output logic                       gate_x,
    output logic                       gate_y,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_VEC*OUT_W-1:0]   table_out,
    output logic [NUM_VEC-1:0]         mismatch,
    output logic                       pass
);

    localparam logic [2:0]       c_IDLE      = 3'(ST_IDLE);
    localparam logic [2:0]       c_APPLY     = 3'(ST_APPLY);
    localparam logic [2:0]       c_WAIT      = 3'(ST_WAIT);
    localparam logic [2:0]       c_CAPTURE   = 3'(ST_CAPTURE);
    localparam logic [2:0]       c_DONE      = 3'(ST_DONE);
    localparam logic [CNT_W-1:0] c_SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [1:0]       c_LAST_IDX  = 2'(NUM_VEC - 1);

    logic [2:0]               state_q,    state_d;
    logic [1:0]               idx_q,      idx_d;
    logic [CNT_W-1:0]         cnt_q,      cnt_d;
    logic [NUM_VEC*OUT_W-1:0] table_q,    table_d;
    logic [NUM_VEC-1:0]       mismatch_q, mismatch_d;
    logic                     pass_q,     pass_d;
    logic                     done_q,     done_d;
    logic                     start_prev_q;

    logic                     w_start_req;
    logic [NUM_VEC-1:0]       w_mismatch;

    // A start held high across several cycles is a single request.
    assign w_start_req = start & ~start_prev_q;

    for (genvar i = 0; i < NUM_VEC; i++) begin : g_row_cmp
        assign w_mismatch[i] = (table_q[i*OUT_W +: OUT_W] != exp_table[i*OUT_W +: OUT_W]);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        table_d    = table_q;
        mismatch_d = mismatch_q;
        pass_d     = pass_q;
        done_d     = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (w_start_req) begin
                    state_d    = c_APPLY;
                    idx_d      = 2'd0;
                    table_d    = '0;
                    mismatch_d = '0;
                    pass_d     = 1'b0;
                end
            end
            c_APPLY: begin
                cnt_d   = c_SETTLE_LD;
                state_d = c_WAIT;
            end
            c_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = c_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            c_CAPTURE: begin
                for (int i = 0; i < NUM_VEC; i++) begin
                    if (idx_q == 2'(i)) begin
                        table_d[i*OUT_W +: OUT_W] = gate_out;
                    end
                end
                if (idx_q == c_LAST_IDX) begin
                    state_d = c_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = c_APPLY;
                end
            end
            c_DONE: begin
                // Expected table is only looked at here, once the capture is complete.
                done_d     = 1'b1;
                mismatch_d = w_mismatch;
                pass_d     = (w_mismatch == '0);
                state_d    = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= c_IDLE;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            table_q      <= '0;
            mismatch_q   <= '0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            table_q      <= table_d;
            mismatch_q   <= mismatch_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
            start_prev_q <= start;
        end
    end

    assign gate_x    = idx_q[1];
    assign gate_y    = idx_q[0];
    assign busy      = (state_q != c_IDLE);
    assign done      = done_q;
    assign table_out = table_q;
    assign mismatch  = mismatch_q;
    assign pass      = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
// ============================================================================
//  Module      : tb_gate_sweep_ctrl
//  Description : Self-checking bench: three controllers (SETTLE 2, 1, 15)
//                sweeping a behavioural gate unit with optional faults.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_sweep_ctrl;

    localparam int W  = 10;
    localparam int NV = 4;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst;
    logic start;

    logic [W-1:0]      unit_tab   [NV];
    logic [W-1:0]      fault_mask [NV];
    logic [NV*W-1:0]   exp_table;

    logic              gx    [ND];
    logic              gy    [ND];
    logic              busy  [ND];
    logic              done  [ND];
    logic              pass  [ND];
    logic [W-1:0]      gout  [ND];
    logic [NV*W-1:0]   tab   [ND];
    logic [NV-1:0]     mm    [ND];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic int settle_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 15;
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        // Gate unit stand-in: truth table lookup with an optional per-row fault.
        assign gout[g] = unit_tab[{gx[g], gy[g]}] ^ fault_mask[{gx[g], gy[g]}];

        gate_sweep_ctrl #(
            .SETTLE (settle_of(g)),
            .OUT_W  (W)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .gate_out  (gout[g]),
            .exp_table (exp_table),
            .gate_x    (gx[g]),
            .gate_y    (gy[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .table_out (tab[g]),
            .mismatch  (mm[g]),
            .pass      (pass[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // z1..z6, w1..w3, z of a healthy gate unit for operands x, y.
    function automatic logic [W-1:0] good_gate(input logic x, input logic y);
        logic [W-1:0] r;
        r[0] = x & y;
        r[1] = x | y;
        r[2] = x ^ y;
        r[3] = ~(x & y);
        r[4] = ~(x | y);
        r[5] = ~(x ^ y);
        r[6] = x & ~y;
        r[7] = ~x & y;
        r[8] = ~x;
        r[9] = ~y;
        return r;
    endfunction

    task automatic load_unit(input bit randomize_tab);
        logic [1:0] rv;
        for (int r = 0; r < NV; r++) begin
            rv = 2'(r);
            unit_tab[r]   = randomize_tab ? W'($urandom) : good_gate(rv[1], rv[0]);
            fault_mask[r] = '0;
            exp_table[r*W +: W] = unit_tab[r];
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int g = 0; g < ND; g++) begin
            chk($sformatf("%s_busy%0d", tag, g), 64'(busy[g]), 64'd0);
            chk($sformatf("%s_done%0d", tag, g), 64'(done[g]), 64'd0);
            chk($sformatf("%s_vec%0d",  tag, g), 64'({gx[g], gy[g]}), 64'd0);
            chk($sformatf("%s_tab%0d",  tag, g), 64'(tab[g]), 64'd0);
            chk($sformatf("%s_mm%0d",   tag, g), 64'(mm[g]), 64'd0);
            chk($sformatf("%s_pass%0d", tag, g), 64'(pass[g]), 64'd0);
        end
    endtask

    // Drive one sweep and check every controller cycle by cycle against the
    // timing rule: each vector lasts SETTLE+2 cycles, done one cycle after that.
    task automatic sweep(input string tag, input int hold, input int len);
        int s, ks, ev;
        logic [NV*W-1:0] exp_tab;
        logic [NV-1:0]   exp_mm;
        start = 1'b1;
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            if (k + 1 >= hold) start = 1'b0;
            for (int g = 0; g < ND; g++) begin
                s  = settle_of(g);
                ks = 4 * (s + 2);
                ev = (k < ks) ? k / (s + 2) : 3;
                chk($sformatf("%s_vec%0d_k%0d",  tag, g, k), 64'({gx[g], gy[g]}), 64'(ev));
                chk($sformatf("%s_busy%0d_k%0d", tag, g, k), 64'(busy[g]), 64'(k <= ks));
                chk($sformatf("%s_done%0d_k%0d", tag, g, k), 64'(done[g]), 64'(k == ks + 1));
            end
        end
        start = 1'b0;
        for (int r = 0; r < NV; r++) begin
            exp_tab[r*W +: W] = unit_tab[r] ^ fault_mask[r];
            exp_mm[r]         = (fault_mask[r] != '0);
        end
        for (int g = 0; g < ND; g++) begin
            chk($sformatf("%s_tab%0d",  tag, g), 64'(tab[g]), 64'(exp_tab));
            chk($sformatf("%s_mm%0d",   tag, g), 64'(mm[g]), 64'(exp_mm));
            chk($sformatf("%s_pass%0d", tag, g), 64'(pass[g]), 64'(exp_mm == '0));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        load_unit(1'b0);
        @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Healthy gate unit, single-cycle start.
        sweep("good", 1, 72);

        // z1 (AND) stuck at 0: only row 3 reads differently.
        fault_mask[3] = 10'h001;
        sweep("and_sa0", 1, 72);
        load_unit(1'b0);

        // Held start gives one sweep; a fresh pulse afterwards gives another.
        sweep("held", 20, 72);
        sweep("again", 1, 72);

        // Reset in the WAIT of vector 10 of the SETTLE=2 controller.
        start = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("midrst_pre_vec", 64'({gx[0], gy[0]}), 64'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("midrst");
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < ND; g++) begin
                chk($sformatf("midrst_nodone%0d_k%0d", g, k), 64'(done[g]), 64'd0);
            end
        end
        sweep("post_rst", 1, 72);

        // Reset wins over start in the same cycle.
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        check_all_zero("rst_start");
        @(posedge clk);
        #1;
        for (int g = 0; g < ND; g++) begin
            chk($sformatf("rst_start_idle%0d", g), 64'(busy[g]), 64'd0);
        end

        // Random truth tables with random faulty rows.
        for (int n = 0; n < 6; n++) begin
            load_unit(1'b1);
            for (int r = 0; r < NV; r++) begin
                fault_mask[r] = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
            end
            sweep($sformatf("rand%0d", n), $urandom_range(1, 3), 72);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 Parameter SETTLE, default 2, wait cycles between applying a vector and sampling the gate unit; legal range 1..15.
REQ-002 Parameter OUT_W, default 10, width of the gate unit result bus (z1..z6, w1..w3, z, LSB = z1).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1, rising-edge clock.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port start, input, 1, single-cycle request to begin a sweep.
REQ-007 Port gate_out, input, OUT_W, result bus from the gate unit.
REQ-008 Port exp_table, input, 4*OUT_W, expected truth table; row i at bits [i*OUT_W +: OUT_W].
REQ-009 Port gate_x, output, 1, x operand driven to the gate unit.
REQ-010 Port gate_y, output, 1, y operand driven to the gate unit.
REQ-011 Port busy, output, 1, high while a sweep is in progress.
REQ-012 Port done, output, 1, one-cycle pulse at sweep completion.
REQ-013 Port table_out, output, 4*OUT_W, captured truth table; same row layout as exp_table.
REQ-014 Port mismatch, output, 4, bit i set when captured row i differs from expected row i.
REQ-015 Port pass, output, 1, high when all four rows match.

Function
REQ-016 The FSM SHALL have states IDLE, APPLY, WAIT, CAPTURE and DONE.
REQ-017 IDLE: when start is sampled high, go to APPLY, set the vector index idx to 0, clear table_out, mismatch and pass.
REQ-018 gate_x SHALL equal idx[1] and gate_y SHALL equal idx[0], both registered, so the vector order is 00, 01, 10, 11.
REQ-019 APPLY (1 cycle): load the settle counter with SETTLE-1, then go to WAIT.
REQ-020 WAIT: decrement the counter each cycle; when the counter is 0, go to CAPTURE, so WAIT lasts exactly SETTLE cycles.
REQ-021 CAPTURE (1 cycle): write gate_out into row idx of table_out.
REQ-022 From CAPTURE: if idx equals 3, go to DONE; otherwise increment idx and go to APPLY.
REQ-023 DONE (1 cycle): done=1; register mismatch[i] = (row i != expected row i), pass = (mismatch == 0); then go to IDLE.
REQ-024 exp_table SHALL be sampled only in DONE.
REQ-025 Latency: done SHALL be high exactly 4*(SETTLE+2)+1 cycles after the edge that samples start.
REQ-026 busy SHALL be high in every state except IDLE.
REQ-027 start SHALL be ignored while busy, including in the DONE cycle.
REQ-028 After DONE, table_out, mismatch and pass SHALL hold their values until the next accepted start.
REQ-029 idx SHALL never exceed 3 and SHALL NOT wrap within a sweep.

Reset
REQ-030 rst SHALL take priority over all other inputs, including start in the same cycle.
REQ-031 On reset: state=IDLE, idx=0, counter=0, gate_x=0, gate_y=0, busy=0, done=0, table_out=0, mismatch=0, pass=0.
REQ-032 Reset mid-sweep SHALL abort the sweep with no done pulse; the next start SHALL begin a fresh sweep from vector 00.

Structure
REQ-033 Package gate_sweep_pkg SHALL hold the state enum typedef, NUM_VEC=4 and the default OUT_W.
REQ-034 The gate unit SHALL stay external and be connected at the testbench or top level.
REQ-035 The block SHALL be a single module with no sub-modules.

Verification
REQ-036 SETTLE=2, exp_table matches a correct gate unit, start pulsed -> gate_x/gate_y step 00,01,10,11; done at cycle 17; pass=1; mismatch=0000.
REQ-037 Gate unit with z1 (AND) stuck at 0 -> row 3 bit 0 captured as 0; mismatch=1000; pass=0.
REQ-038 start held high for 20 cycles -> exactly one sweep and one done pulse; a new start one cycle after done -> second sweep begins.
REQ-039 rst asserted during the WAIT of vector 10 -> all outputs 0 next cycle, no done pulse; a subsequent start completes normally with pass=1.
REQ-040 SETTLE=1 and SETTLE=15 -> done at cycle 13 and cycle 69 respectively; each vector is held stable for exactly SETTLE+2 cycles.
REQ-041 rst and start high in the same cycle -> block stays in IDLE with busy=0.
